// File: rtl/hex_entry_encoder.sv
`default_nettype none
// ============================================================================
// Module   : hex_entry_encoder
// Brief    : Debounced push-button editor for a multi-digit hex value with
//            cursor selection and a one-cycle commit strobe.
// Revision : 1.0 - initial release
// ============================================================================
module hex_entry_encoder #(
  parameter int         DIGITS          = 2,
  parameter int         DEBOUNCE_CYCLES = 500000,
  parameter logic [3:0] MAX_DIGIT       = 4'hF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  btn_inc,
  input  logic                  btn_dec,
  input  logic                  btn_next,
  input  logic                  btn_enter,
  output logic [4*DIGITS-1:0]   value,
  output logic [1:0]            cursor,
  output logic                  commit,
  output logic                  busy
);

  localparam int               c_CNT_W       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]       c_CURSOR_LAST = 2'(DIGITS - 1);
  localparam int               c_BTN_INC     = 0;
  localparam int               c_BTN_DEC     = 1;
  localparam int               c_BTN_NEXT    = 2;
  localparam int               c_BTN_ENTER   = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EDIT   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  logic [3:0] w_raw;
  logic [3:0] w_press;

  assign w_raw = {btn_enter, btn_next, btn_dec, btn_inc};

  for (genvar b = 0; b < 4; b++) begin : g_btn
    logic               r_sync1;
    logic               r_sync2;
    logic               r_db;
    logic               r_db_d;
    logic               r_press;
    logic [c_CNT_W-1:0] r_cnt;

    // Counter only advances while the synchronised level disagrees with db.
    always_ff @(posedge clock) begin
      if (reset) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
        r_db    <= 1'b0;
        r_db_d  <= 1'b0;
        r_press <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_sync1 <= w_raw[b];
        r_sync2 <= r_sync1;
        r_db_d  <= r_db;
        r_press <= r_db & ~r_db_d;
        if (r_sync2 == r_db) begin
          r_cnt <= '0;
        end else if (r_cnt == c_CNT_LAST) begin
          r_db  <= r_sync2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + c_CNT_W'(1);
        end
      end
    end

    assign w_press[b] = r_press;
  end

  state_t              r_state;
  logic [4*DIGITS-1:0] r_value;
  logic [1:0]          r_cursor;
  logic                r_commit;
  logic                r_busy;
  logic [4*DIGITS-1:0] w_inc_value;
  logic [4*DIGITS-1:0] w_dec_value;

  // Wrapped per-digit results for the selected digit; no carry between digits.
  always_comb begin
    w_inc_value = r_value;
    w_dec_value = r_value;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_cursor == 2'(i)) begin
        w_inc_value[4*i +: 4] = (r_value[4*i +: 4] == MAX_DIGIT) ? 4'd0
                                                                 : r_value[4*i +: 4] + 4'd1;
        w_dec_value[4*i +: 4] = (r_value[4*i +: 4] == 4'd0) ? MAX_DIGIT
                                                            : r_value[4*i +: 4] - 4'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_value  <= '0;
      r_cursor <= 2'd0;
      r_commit <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_commit <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            r_state <= ST_EDIT;
            r_busy  <= 1'b1;
          end
        end
        ST_EDIT: begin
          if (!enable) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_press[c_BTN_ENTER]) begin
            r_state  <= ST_COMMIT;
            r_commit <= 1'b1;
            r_busy   <= 1'b0;
          end else if (w_press[c_BTN_NEXT]) begin
            r_cursor <= (r_cursor == c_CURSOR_LAST) ? 2'd0 : r_cursor + 2'd1;
          end else if (w_press[c_BTN_INC]) begin
            r_value <= w_inc_value;
          end else if (w_press[c_BTN_DEC]) begin
            r_value <= w_dec_value;
          end
        end
        ST_COMMIT: begin
          r_state <= enable ? ST_EDIT : ST_IDLE;
          r_busy  <= enable;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign value  = r_value;
  assign cursor = r_cursor;
  assign commit = r_commit;
  assign busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_hex_entry_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_entry_encoder
// Brief    : Directed plus random stimulus against an event-level model of
//            the hex entry editor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_entry_encoder;

  localparam int         DC     = 4;
  localparam int         ND     = 2;
  localparam logic [3:0] MAXD   = 4'd9;
  localparam int         MAXD_I = 9;
  localparam int         M_IDLE   = 0;
  localparam int         M_EDIT   = 1;
  localparam int         M_COMMIT = 2;

  logic       clock  = 1'b0;
  logic       reset  = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] btn    = '0;   // 0 inc, 1 dec, 2 next, 3 enter
  logic [7:0] value;
  logic [1:0] cursor;
  logic       commit;
  logic       busy;

  int checks = 0;
  int errors = 0;

  hex_entry_encoder #(
    .DIGITS          (ND),
    .DEBOUNCE_CYCLES (DC),
    .MAX_DIGIT       (MAXD)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .btn_inc   (btn[0]),
    .btn_dec   (btn[1]),
    .btn_next  (btn[2]),
    .btn_enter (btn[3]),
    .value     (value),
    .cursor    (cursor),
    .commit    (commit),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a level is accepted once the last DC synchronised
  // samples all disagree with it; a 0->1 acceptance acts two edges later.
  logic [3:0]    m_q1, m_q2, m_db, m_ev_a, m_ev_b;
  logic [DC-1:0] m_win [4];
  int            m_mode;
  int            m_dig [ND];
  int            m_cur;

  initial begin
    logic [3:0] s, rise, act;
    forever begin
      @(posedge clock);
      if (reset) begin
        m_q1 = '0; m_q2 = '0; m_db = '0; m_ev_a = '0; m_ev_b = '0;
        for (int b = 0; b < 4; b++) m_win[b] = '0;
        m_mode = M_IDLE;
        foreach (m_dig[d]) m_dig[d] = 0;
        m_cur = 0;
      end else begin
        s = m_q2; m_q2 = m_q1; m_q1 = btn;
        rise = '0;
        for (int b = 0; b < 4; b++) begin
          m_win[b] = {m_win[b][DC-2:0], s[b]};
          if (m_win[b] == {DC{~m_db[b]}}) begin
            rise[b]  = ~m_db[b];
            m_db[b]  = ~m_db[b];
            m_win[b] = {DC{m_db[b]}};
          end
        end
        act = m_ev_b; m_ev_b = m_ev_a; m_ev_a = rise;
        case (m_mode)
          M_IDLE: if (enable) m_mode = M_EDIT;
          M_EDIT: begin
            if (!enable)     m_mode = M_IDLE;
            else if (act[3]) m_mode = M_COMMIT;
            else if (act[2]) m_cur = (m_cur + 1) % ND;
            else if (act[0]) m_dig[m_cur] = (m_dig[m_cur] == MAXD_I) ? 0 : m_dig[m_cur] + 1;
            else if (act[1]) m_dig[m_cur] = (m_dig[m_cur] == 0) ? MAXD_I : m_dig[m_cur] - 1;
          end
          default: m_mode = enable ? M_EDIT : M_IDLE;
        endcase
      end
      #1;
      check("value",  32'(value),  32'(m_dig[1] * 16 + m_dig[0]));
      check("cursor", 32'(cursor), 32'(m_cur));
      check("commit", 32'(commit), 32'(m_mode == M_COMMIT));
      check("busy",   32'(busy),   32'(m_mode == M_EDIT));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press(input int b, input int hold, input int gap);
    btn[b] = 1'b1;
    tick(hold);
    btn[b] = 1'b0;
    tick(gap);
  endtask

  task automatic count_commits(output int n, output logic [7:0] v);
    n = 0;
    v = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      if (commit) begin
        n++;
        v = value;
      end
    end
  endtask

  initial begin
    int         ncommit;
    logic [7:0] cval;
    int         hold [4];

    reset = 1'b1; tick(3); reset = 1'b0;
    enable = 1'b1; tick(2);

    // Held inc: one increment, exactly DC+4 edges after the raw rise.
    btn[0] = 1'b1;
    repeat (7) @(posedge clock);
    #1 check("t1_early", 32'(value), 32'h00);
    @(posedge clock);
    #1 check("t1_value", 32'(value), 32'h01);
    check("t1_busy", 32'(busy), 32'h1);
    tick(2); btn[0] = 1'b0; tick(8);
    check("t1_single", 32'(value), 32'h01);

    // Wrap up through MAX_DIGIT and back down.
    repeat (8) press(0, 6, 8);
    check("t2_nine", 32'(value), 32'h09);
    press(0, 6, 8);
    check("t2_wrap_up", 32'(value), 32'h00);
    press(1, 6, 8);
    check("t2_wrap_down", 32'(value), 32'h09);
    press(0, 6, 8);

    // Cursor move, edit upper digit, commit.
    press(2, 6, 8);
    repeat (3) press(0, 6, 8);
    check("t3_cursor", 32'(cursor), 32'h1);
    check("t3_value", 32'(value), 32'h30);
    btn[3] = 1'b1;
    count_commits(ncommit, cval);
    @(negedge clock); btn[3] = 1'b0; tick(8);
    check("t3_commit_cnt", 32'(ncommit), 32'h1);
    check("t3_commit_val", 32'(cval), 32'h30);

    // Glitches and bounce.
    repeat (3) press(0, 3, 5);
    check("t4_glitch", 32'(value), 32'h30);
    btn[0] = 1'b1; tick(1); btn[0] = 1'b0; tick(1);
    btn[0] = 1'b1; tick(2); btn[0] = 1'b0; tick(1);
    press(0, 6, 8);
    check("t4_stable", 32'(value), 32'h40);

    // Coincident enter and inc: enter wins.
    btn[0] = 1'b1; btn[3] = 1'b1;
    count_commits(ncommit, cval);
    @(negedge clock); btn = '0; tick(8);
    check("t5_commit_cnt", 32'(ncommit), 32'h1);
    check("t5_commit_val", 32'(cval), 32'h40);
    check("t5_value", 32'(value), 32'h40);
    enable = 1'b0; tick(2);
    check("t5_idle_busy", 32'(busy), 32'h0);
    press(0, 6, 8);
    press(2, 6, 8);
    check("t5_held_val", 32'(value), 32'h40);
    check("t5_held_cur", 32'(cursor), 32'h1);

    // Reset two cycles before the press event would fire.
    enable = 1'b1; tick(2);
    btn[0] = 1'b1; tick(4);
    reset = 1'b1; btn[0] = 1'b0; tick(1); reset = 1'b0;
    check("t6_value", 32'(value), 32'h00);
    check("t6_cursor", 32'(cursor), 32'h0);
    check("t6_busy", 32'(busy), 32'h0);
    check("t6_commit", 32'(commit), 32'h0);
    tick(15);
    check("t6_no_event", 32'(value), 32'h00);

    // Random buttons, enable drops and occasional reset.
    for (int b = 0; b < 4; b++) hold[b] = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clock);
      for (int b = 0; b < 4; b++) begin
        if (hold[b] == 0) begin
          btn[b]  = ($urandom_range(0, 2) == 0);
          hold[b] = int'($urandom_range(1, 12));
        end else begin
          hold[b]--;
        end
      end
      enable = ($urandom_range(0, 19) != 0);
      reset  = ($urandom_range(0, 299) == 0);
    end
    reset = 1'b0; btn = '0;
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hex_entry_encoder.md
# hex_entry_encoder

Sequential input-side counterpart of the seven-segment hex display path. It turns raw push-button activity into multi-digit hex values (e.g. a battleship target coordinate) that the game logic consumes and the display decoders echo back. The block synchronises and debounces four buttons, edits a cursor-selected digit with increment and decrement, and emits a one-cycle commit strobe with the entered value. It sits between the top-level KEY inputs (already inverted to active-high) and the game FSM.

## Interface
- `DIGITS`, 2: number of hex digits entered; legal range 1..4.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable synchronised samples required to accept a level change; legal range ≥ 2.
- `MAX_DIGIT`, 4'hF: largest legal value per digit; digits wrap within 0..MAX_DIGIT.
- `clock`, in, 1: sole clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high; one clock is sufficient.
- `enable`, in, 1: when low, editing is frozen and press events are discarded.
- `btn_inc` / `btn_dec` / `btn_next` / `btn_enter`, in, 1 each: raw asynchronous button levels, 1 = pressed.
- `value`, out, 4*DIGITS: entered digits; digit 0 is `value[3:0]`.
- `cursor`, out, 2: index of the digit being edited.
- `commit`, out, 1: one-cycle strobe; `value` is valid in that cycle.
- `busy`, out, 1: high while in EDIT.

## Operation
- Per button:
  - Two-flop synchroniser.
  - Debounce counter with accepted level `db`.
  - Any synchronised sample equal to `db` clears the counter.
  - After DEBOUNCE_CYCLES consecutive differing samples, `db` takes the new level and the counter clears.
  - A registered press event fires for exactly one cycle on each 0→1 transition of `db`. Releases generate no event.
- States:
  - IDLE → EDIT on the first cycle with `enable`=1.
  - EDIT → COMMIT on an enter event.
  - COMMIT lasts one cycle, asserts `commit`, then returns to EDIT, or to IDLE if `enable`=0.
  - EDIT → IDLE whenever `enable`=0.
  - IDLE keeps `value` and `cursor`; events arriving in IDLE or COMMIT are dropped.
- EDIT actions (at most one per cycle):
  - Priority when events coincide: enter > next > inc > dec. Lower-priority events in the same cycle are dropped.
  - inc: the digit at `cursor` becomes 0 if it equals MAX_DIGIT, else +1.
  - dec: the digit at `cursor` becomes MAX_DIGIT if it equals 0, else −1.
  - next: `cursor` becomes 0 if it equals DIGITS−1, else +1.
- Digit arithmetic is 4-bit with no carry between digits. A digit never holds a value above MAX_DIGIT. `cursor` never exceeds DIGITS−1.
- Reset values:
  - `value`=0, `cursor`=0, `commit`=0, `busy`=0.
  - State IDLE.
  - All synchronisers, `db` levels and debounce counters are 0.
- Reset mid-debounce or mid-commit discards the pending event and any strobe; no commit is produced for a press that straddles reset.
- A held button produces exactly one event; there is no auto-repeat.

## Timing
- Raw press rising at edge t (stable thereafter):
  - `db` rises at t+2+DEBOUNCE_CYCLES.
  - The event pulse is high during cycle t+3+DEBOUNCE_CYCLES.
  - The updated `value`/`cursor`, or the `commit` strobe, appears at t+4+DEBOUNCE_CYCLES.
  - Total latency is DEBOUNCE_CYCLES+4 clocks.
- Glitches shorter than DEBOUNCE_CYCLES synchronised cycles produce no event.
- `value` is stable throughout the `commit` cycle and does not change in the cycle after it.
- `busy` is registered and tracks the state: 1 in EDIT, 0 in IDLE and COMMIT.

## Test plan
Bench settings: DEBOUNCE_CYCLES=4, DIGITS=2, MAX_DIGIT=9.
1. Reset then `enable`=1, hold `btn_inc` high for 10 cycles → `value`=8'h01 exactly 8 cycles after the press; a single increment only; `busy`=1.
2. Press inc 10 times, releasing ≥6 cycles between presses → digit 0 goes 1..9 then wraps to 0. Press dec once from 0 → 9.
3. Press next, then inc 3 times, then enter → `cursor`=1, `value`=8'h30; `commit` high for exactly 1 cycle with `value`=8'h30.
4. 3-cycle glitches on `btn_inc`, plus a bounce pattern 1,0,1,1,0 before a stable press → zero events from the glitches, exactly one event from the stable press.
5. Raise `btn_enter` and `btn_inc` on the same cycle → `commit` asserted, `value` unchanged. Drop `enable` during EDIT → IDLE, subsequent presses ignored, `value` held.
6. Assert `reset` 2 cycles before a pending press event → no event, all outputs 0 after reset.
